// File: rtl/numeric_display_scanner.sv
// Multiplexed 7-segment scan driver.
// A slot counter walks each digit in turn; every slot starts with a short dark
// gap (anti-ghosting) followed by a PWM-shaped lit window. Written values land
// in a staging buffer and only move to the displayed shadow copy at a frame
// boundary, so a frame never shows a mix of old and new digits.
module numeric_display_scanner #(
   parameter int   C_DIGITS     = 4,
   parameter int   C_SCAN_DIV   = 2500,
   parameter int   C_GAP_CYCLES = 16,
   parameter logic C_SEG_ACTIVE = 1'b0,
   parameter logic C_DIG_ACTIVE = 1'b0
) (
   input  logic                    MCLK,
   input  logic                    nRST,
   input  logic                    EN,
   input  logic [4*C_DIGITS-1:0]   VALUE,
   input  logic [C_DIGITS-1:0]     DOTS,
   input  logic                    LZ_BLANK,
   input  logic [3:0]              BRIGHT,
   input  logic                    WR,
   output logic                    WR_ACK,
   output logic [7:0]              SEG,
   output logic [C_DIGITS-1:0]     DIG,
   output logic                    FRAME
);

   // Counter widths; a degenerate 1-cycle slot or single digit still gets one bit.
   localparam int CW = (C_SCAN_DIV > 1) ? $clog2(C_SCAN_DIV) : 1;
   localparam int IW = (C_DIGITS > 1) ? $clog2(C_DIGITS) : 1;
   // Usable (non-gap) part of a slot and the width of the W*(b+1) product.
   localparam int W  = C_SCAN_DIV - C_GAP_CYCLES;
   localparam int PW = $clog2(W) + 5;
   // Comparison width wide enough for both cnt and GAP+ON without overflow.
   localparam int XW = ((CW > PW) ? CW : PW) + 1;

   localparam logic [7:0]          SEG_OFF = {8{~C_SEG_ACTIVE}};
   localparam logic [C_DIGITS-1:0] DIG_OFF = {C_DIGITS{~C_DIG_ACTIVE}};

   // Scan state
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [3:0]    b_q, b_d;

   // Staging (written, not yet shown) and shadow (currently shown) buffers
   logic [4*C_DIGITS-1:0] stg_val_q, stg_val_d;
   logic [C_DIGITS-1:0]   stg_dots_q, stg_dots_d;
   logic                  stg_lz_q, stg_lz_d;
   logic                  pend_q, pend_d;
   logic [4*C_DIGITS-1:0] shd_val_q, shd_val_d;
   logic [C_DIGITS-1:0]   shd_dots_q, shd_dots_d;
   logic                  shd_lz_q, shd_lz_d;

   // Registered pin drive
   logic [7:0]          seg_q, seg_d;
   logic [C_DIGITS-1:0] dig_q, dig_d;
   logic                ack_q, ack_d;
   logic                frame_q, frame_d;

   // Decoded helpers
   logic                cnt_last;
   logic                idx_last;
   logic                boundary;
   logic [3:0]          b_eff;
   logic [PW-1:0]       b_plus1;
   logic [PW-1:0]       on_prod;
   logic [PW-1:0]       on_cyc;
   logic [XW-1:0]       cnt_x;
   logic [XW-1:0]       on_x;
   logic                lit;
   logic [3:0]          nib [C_DIGITS];
   logic [C_DIGITS-1:0] dig_sel;
   logic [C_DIGITS-1:0] blank;
   logic                zero_run;
   logic [6:0]          seg_pat;

   // Hex digit to segment pattern, bit 0 = a ... bit 6 = g, active high.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      hex7 = 7'h00;
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         4'hF: hex7 = 7'h71;
         default: hex7 = 7'h00;
      endcase
   endfunction

   // Per-digit nibble view of the shadow value and one-hot digit select.
   genvar gi;
   generate
      for (gi = 0; gi < C_DIGITS; gi++) begin : g_digit
         assign nib[gi]     = shd_val_q[4*gi +: 4];
         assign dig_sel[gi] = (idx_q == IW'(gi));
      end
   endgenerate

   assign cnt_last = (cnt_q == CW'(C_SCAN_DIV - 1));
   assign idx_last = (idx_q == IW'(C_DIGITS - 1));
   // While disabled every cycle is treated as a boundary so writes land at once.
   assign boundary = !EN || (cnt_last && idx_last);

   // Brightness is latched at slot start; at cnt=0 itself the live input is used
   // so a zero-gap configuration still lights the first cycle correctly.
   assign b_eff   = (cnt_q == '0) ? BRIGHT : b_q;
   assign b_plus1 = PW'(b_eff) + PW'(1);
   assign on_prod = PW'(W) * b_plus1;
   assign on_cyc  = on_prod >> 4;
   assign cnt_x   = XW'(cnt_q);
   assign on_x    = XW'(on_cyc);
   assign lit     = (cnt_x >= XW'(C_GAP_CYCLES)) && (cnt_x < (XW'(C_GAP_CYCLES) + on_x));

   // Leading-zero mask: walk from the MSD down while digits stay zero; digit 0 is kept.
   always_comb begin
      blank    = '0;
      zero_run = 1'b1;
      for (int i = C_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (nib[i] == 4'h0);
         if (i != 0) begin
            blank[i] = shd_lz_q && zero_run;
         end
      end
   end

   // Next slot counter, digit index and latched brightness.
   always_comb begin
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      b_d     = b_q;
      frame_d = 1'b0;
      if (!EN) begin
         cnt_d = '0;
         idx_d = '0;
      end else begin
         if (cnt_q == '0) begin
            b_d = BRIGHT;
         end
         if (cnt_last) begin
            cnt_d = '0;
            idx_d = idx_last ? '0 : idx_q + IW'(1);
            frame_d = idx_last;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Write capture and frame-boundary transfer from staging to shadow.
   always_comb begin
      stg_val_d  = stg_val_q;
      stg_dots_d = stg_dots_q;
      stg_lz_d   = stg_lz_q;
      pend_d     = pend_q;
      shd_val_d  = shd_val_q;
      shd_dots_d = shd_dots_q;
      shd_lz_d   = shd_lz_q;
      ack_d      = 1'b0;
      if (boundary) begin
         if (WR) begin
            // A write coinciding with the boundary skips staging entirely.
            shd_val_d  = VALUE;
            shd_dots_d = DOTS;
            shd_lz_d   = LZ_BLANK;
            pend_d     = 1'b0;
            ack_d      = 1'b1;
         end else if (pend_q) begin
            shd_val_d  = stg_val_q;
            shd_dots_d = stg_dots_q;
            shd_lz_d   = stg_lz_q;
            pend_d     = 1'b0;
            ack_d      = 1'b1;
         end
      end else if (WR) begin
         // Repeated writes before a boundary simply overwrite staging.
         stg_val_d  = VALUE;
         stg_dots_d = DOTS;
         stg_lz_d   = LZ_BLANK;
         pend_d     = 1'b1;
      end
   end

   // Pin pattern for the current cnt/idx, registered below for a clean one-cycle latency.
   always_comb begin
      seg_pat = blank[idx_q] ? 7'h00 : hex7(nib[idx_q]);
      seg_d   = SEG_OFF;
      dig_d   = DIG_OFF;
      if (EN && lit) begin
         seg_d = {shd_dots_q[idx_q], seg_pat} ~^ {8{C_SEG_ACTIVE}};
         dig_d = dig_sel ~^ {C_DIGITS{C_DIG_ACTIVE}};
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge MCLK) begin
      if (!nRST) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         b_q        <= '0;
         stg_val_q  <= '0;
         stg_dots_q <= '0;
         stg_lz_q   <= 1'b0;
         pend_q     <= 1'b0;
         shd_val_q  <= '0;
         shd_dots_q <= '0;
         shd_lz_q   <= 1'b0;
         seg_q      <= SEG_OFF;
         dig_q      <= DIG_OFF;
         ack_q      <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         b_q        <= b_d;
         stg_val_q  <= stg_val_d;
         stg_dots_q <= stg_dots_d;
         stg_lz_q   <= stg_lz_d;
         pend_q     <= pend_d;
         shd_val_q  <= shd_val_d;
         shd_dots_q <= shd_dots_d;
         shd_lz_q   <= shd_lz_d;
         seg_q      <= seg_d;
         dig_q      <= dig_d;
         ack_q      <= ack_d;
         frame_q    <= frame_d;
      end
   end

   assign SEG    = seg_q;
   assign DIG    = dig_q;
   assign WR_ACK = ack_q;
   assign FRAME  = frame_q;

endmodule

// File: tb/tb_numeric_display_scanner.sv
// Directed bench for numeric_display_scanner: 4 digits, 8-cycle slots,
// 2-cycle gap, active-low pins, 32-cycle frame.
module tb_numeric_display_scanner;

   logic        MCLK;
   logic        nRST;
   logic        EN;
   logic [15:0] VALUE;
   logic [3:0]  DOTS;
   logic        LZ_BLANK;
   logic [3:0]  BRIGHT;
   logic        WR;
   logic        WR_ACK;
   logic [7:0]  SEG;
   logic [3:0]  DIG;
   logic        FRAME;

   int checks = 0;
   int errors = 0;

   // One frame of observations, index k = sample k+1 negedges after a frame start.
   logic [7:0]  seg_obs [32];
   logic [3:0]  dig_obs [32];
   logic        frm_obs [32];
   logic        ack_obs [32];

   // Stimulus applied just before sample k is taken.
   logic        ev_wr   [32];
   logic [15:0] ev_val  [32];
   logic [3:0]  ev_dots [32];
   logic        ev_lz   [32];
   logic        ev_br   [32];
   logic [3:0]  ev_brv  [32];

   numeric_display_scanner #(
      .C_DIGITS     (4),
      .C_SCAN_DIV   (8),
      .C_GAP_CYCLES (2),
      .C_SEG_ACTIVE (1'b0),
      .C_DIG_ACTIVE (1'b0)
   ) dut (
      .MCLK     (MCLK),
      .nRST     (nRST),
      .EN       (EN),
      .VALUE    (VALUE),
      .DOTS     (DOTS),
      .LZ_BLANK (LZ_BLANK),
      .BRIGHT   (BRIGHT),
      .WR       (WR),
      .WR_ACK   (WR_ACK),
      .SEG      (SEG),
      .DIG      (DIG),
      .FRAME    (FRAME)
   );

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   // Expected {SEG, DIG, FRAME, WR_ACK} for sample k.
   // pat holds active-low SEG bytes {d3,d2,d1,d0}; on holds lit cycles per slot {s3,s2,s1,s0}.
   function automatic logic [13:0] exp_vec(input int k, input logic [31:0] pat,
                                           input logic [15:0] on, input logic ack_end);
      int         s;
      int         c;
      logic       lt;
      logic [7:0] es;
      logic [3:0] ed;
      s  = k / 8;
      c  = k % 8;
      lt = (c >= 2) && (c < 2 + int'(on[4*s +: 4]));
      es = lt ? pat[8*s +: 8] : 8'hFF;
      ed = lt ? ~(4'b0001 << s) : 4'hF;
      return {es, ed, (k == 31), ack_end && (k == 31)};
   endfunction

   function automatic logic [13:0] obs_vec(input int k);
      return {seg_obs[k], dig_obs[k], frm_obs[k], ack_obs[k]};
   endfunction

   task automatic clear_events();
      for (int k = 0; k < 32; k++) begin
         ev_wr[k]   = 1'b0;
         ev_val[k]  = 16'h0;
         ev_dots[k] = 4'h0;
         ev_lz[k]   = 1'b0;
         ev_br[k]   = 1'b0;
         ev_brv[k]  = 4'h0;
      end
   endtask

   // Called at a negedge where cnt=0/idx=0; collects 32 samples.
   task automatic record_frame();
      for (int k = 0; k < 32; k++) begin
         if (ev_wr[k]) begin
            VALUE    = ev_val[k];
            DOTS     = ev_dots[k];
            LZ_BLANK = ev_lz[k];
            WR       = 1'b1;
         end
         if (ev_br[k]) BRIGHT = ev_brv[k];
         @(negedge MCLK);
         WR = 1'b0;
         seg_obs[k] = SEG;
         dig_obs[k] = DIG;
         frm_obs[k] = FRAME;
         ack_obs[k] = WR_ACK;
      end
      clear_events();
   endtask

   task automatic do_write(input logic [15:0] v, input logic [3:0] d, input logic lz);
      VALUE    = v;
      DOTS     = d;
      LZ_BLANK = lz;
      WR       = 1'b1;
      @(negedge MCLK);
      WR = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0; EN = 1'b1; BRIGHT = 4'hF; WR = 1'b0;
      VALUE = 16'h0; DOTS = 4'h0; LZ_BLANK = 1'b0;
      repeat (3) @(negedge MCLK);
      checks++; if (SEG !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h expected ff", SEG); end
      checks++; if (DIG !== 4'hF) begin errors++; $display("FAIL reset_dig got %b expected 1111", DIG); end
      checks++; if (WR_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack got %b expected 0", WR_ACK); end
      checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL reset_frame got %b expected 0", FRAME); end
      $display("test_reset: pins inactive while nRST low");
   endtask

   task automatic test_write_ack();
      logic found;
      nRST = 1'b1;
      repeat (5) @(negedge MCLK);
      do_write(16'h12A0, 4'h0, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge MCLK);
         if (WR_ACK === 1'b1) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL ack_wait got no WR_ACK expected one within 64 cycles"); end
      checks++; if (FRAME !== 1'b1) begin errors++; $display("FAIL ack_with_frame got FRAME=%b expected 1", FRAME); end
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'hF9A488C0, 16'h6666, 1'b0)) begin
            errors++;
            $display("FAIL scan_12A0 k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'hF9A488C0, 16'h6666, 1'b0));
         end
      end
      $display("test_write_ack: 12A0 acked at boundary and scanned");
   endtask

   task automatic test_brightness();
      BRIGHT = 4'd7;
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'hF9A488C0, 16'h3333, 1'b0)) begin
            errors++;
            $display("FAIL bright7 k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'hF9A488C0, 16'h3333, 1'b0));
         end
      end
      BRIGHT = 4'd0;
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'hF9A488C0, 16'h0000, 1'b0)) begin
            errors++;
            $display("FAIL bright0 k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'hF9A488C0, 16'h0000, 1'b0));
         end
      end
      BRIGHT = 4'd15;
      ev_br[3]  = 1'b1;
      ev_brv[3] = 4'd7;
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'hF9A488C0, 16'h3336, 1'b0)) begin
            errors++;
            $display("FAIL bright_midslot k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'hF9A488C0, 16'h3336, 1'b0));
         end
      end
      BRIGHT = 4'd15;
      $display("test_brightness: levels 7, 0 and mid-slot change");
   endtask

   task automatic test_lz_blank();
      logic found;
      do_write(16'h0050, 4'b1000, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge MCLK);
         if (WR_ACK === 1'b1) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL lz_ack_wait got no WR_ACK expected one within 64 cycles"); end
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'h7FFF92C0, 16'h6666, 1'b0)) begin
            errors++;
            $display("FAIL lz_scan k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'h7FFF92C0, 16'h6666, 1'b0));
         end
      end
      $display("test_lz_blank: 0050 with leading zeros blanked, dp on digit 3");
   endtask

   task automatic test_back_to_back();
      ev_wr[3] = 1'b1; ev_val[3] = 16'h1111;
      ev_wr[9] = 1'b1; ev_val[9] = 16'h2222;
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'h7FFF92C0, 16'h6666, 1'b1)) begin
            errors++;
            $display("FAIL b2b_old_frame k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'h7FFF92C0, 16'h6666, 1'b1));
         end
      end
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'hA4A4A4A4, 16'h6666, 1'b0)) begin
            errors++;
            $display("FAIL b2b_new_frame k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'hA4A4A4A4, 16'h6666, 1'b0));
         end
      end
      $display("test_back_to_back: last write wins, single ack at boundary");
   endtask

   task automatic test_boundary_write();
      ev_wr[31] = 1'b1; ev_val[31] = 16'h3333;
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'hA4A4A4A4, 16'h6666, 1'b1)) begin
            errors++;
            $display("FAIL bnd_old_frame k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'hA4A4A4A4, 16'h6666, 1'b1));
         end
      end
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'hB0B0B0B0, 16'h6666, 1'b0)) begin
            errors++;
            $display("FAIL bnd_new_frame k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'hB0B0B0B0, 16'h6666, 1'b0));
         end
      end
      $display("test_boundary_write: write at boundary applied and acked immediately");
   endtask

   task automatic test_reset_mid();
      @(negedge MCLK);
      do_write(16'h5555, 4'h0, 1'b0);
      repeat (3) @(negedge MCLK);
      nRST = 1'b0;
      @(negedge MCLK);
      checks++; if (SEG !== 8'hFF) begin errors++; $display("FAIL midrst_seg got %h expected ff", SEG); end
      checks++; if (DIG !== 4'hF) begin errors++; $display("FAIL midrst_dig got %b expected 1111", DIG); end
      checks++; if (WR_ACK !== 1'b0) begin errors++; $display("FAIL midrst_ack got %b expected 0", WR_ACK); end
      nRST = 1'b1;
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'hC0C0C0C0, 16'h6666, 1'b0)) begin
            errors++;
            $display("FAIL midrst_scan k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'hC0C0C0C0, 16'h6666, 1'b0));
         end
      end
      $display("test_reset_mid: reset at cnt=5 darkens pins and clears pending write");
   endtask

   task automatic test_en_off();
      int n_ack;
      int n_frm;
      int n_lit;
      do_write(16'h4444, 4'h0, 1'b0);
      EN = 1'b0;
      @(negedge MCLK);
      checks++; if (WR_ACK !== 1'b1) begin errors++; $display("FAIL en0_ack got %b expected 1", WR_ACK); end
      checks++; if (SEG !== 8'hFF) begin errors++; $display("FAIL en0_seg got %h expected ff", SEG); end
      checks++; if (DIG !== 4'hF) begin errors++; $display("FAIL en0_dig got %b expected 1111", DIG); end
      checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL en0_frame got %b expected 0", FRAME); end
      n_ack = 0; n_frm = 0; n_lit = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge MCLK);
         if (WR_ACK !== 1'b0) n_ack++;
         if (FRAME !== 1'b0) n_frm++;
         if (SEG !== 8'hFF || DIG !== 4'hF) n_lit++;
      end
      checks++; if (n_ack != 0) begin errors++; $display("FAIL en0_extra_ack got %0d expected 0", n_ack); end
      checks++; if (n_frm != 0) begin errors++; $display("FAIL en0_frames got %0d expected 0", n_frm); end
      checks++; if (n_lit != 0) begin errors++; $display("FAIL en0_lit_cycles got %0d expected 0", n_lit); end
      EN = 1'b1;
      record_frame();
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (obs_vec(k) !== exp_vec(k, 32'h99999999, 16'h6666, 1'b0)) begin
            errors++;
            $display("FAIL en1_scan k=%0d got %h expected %h", k, obs_vec(k), exp_vec(k, 32'h99999999, 16'h6666, 1'b0));
         end
      end
      $display("test_en_off: pending write acked while disabled, scan restarts at digit 0");
   endtask

   initial begin
      clear_events();
      test_reset();
      test_write_ack();
      test_brightness();
      test_lz_blank();
      test_back_to_back();
      test_boundary_write();
      test_reset_mid();
      test_en_off();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
